// File: rtl/instr_fetch_pkg.sv
// Shared definitions for the instruction fetch unit and the microsequencer.
// Holds FSM encodings, default widths and the opcode field position.
package instr_fetch_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_READ = 1'b1
    } state_t;

    localparam int DEF_ADDR_WIDTH   = 16;
    localparam int DEF_DATA_WIDTH   = 16;
    localparam int DEF_OPCODE_WIDTH = 4;

    // Opcode occupies the top bits of the instruction word.
    localparam int DEF_OPCODE_MSB = DEF_DATA_WIDTH - 1;

endpackage

// File: rtl/pc_counter.sv
// Program counter: load has priority over increment, increment wraps modulo 2^WIDTH.
// Latency 1 cycle; no backpressure, acts on every enabled edge.
module pc_counter #(
    parameter int WIDTH    = 16,
    parameter int RESET_PC = 0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             inc,
    output logic [WIDTH-1:0] pc
);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pc <= WIDTH'(RESET_PC);
        end else if (load) begin
            pc <= load_value;
        end else if (inc) begin
            pc <= pc + 1'b1;
        end
    end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch: PC, req/ack memory read into IR, registered ALU flags.
// Latency: >=2 edges fetch-to-IR; READ holds mem_read/mem_addr until mem_ack.
// Optional FETCH_TIMEOUT_EN adds a READ timeout and sticky fetch_error output.
module instr_fetch
    import instr_fetch_pkg::*;
#(
    parameter int ADDR_WIDTH     = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
    parameter int OPCODE_WIDTH   = DEF_OPCODE_WIDTH,
    parameter int RESET_PC       = 0,
    parameter int TIMEOUT_CYCLES = 15
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    fetch,
    input  logic                    pc_load,
    input  logic [ADDR_WIDTH-1:0]   pc_load_value,
    input  logic                    flags_load,
    input  logic                    alu_carry,
    input  logic                    alu_zero,
    output logic [ADDR_WIDTH-1:0]   mem_addr,
    output logic                    mem_read,
    input  logic                    mem_ack,
    input  logic [DATA_WIDTH-1:0]   mem_data,
    output logic [DATA_WIDTH-1:0]   ir,
    output logic [OPCODE_WIDTH-1:0] opcode,
    output logic                    carry,
    output logic                    zero,
    output logic [ADDR_WIDTH-1:0]   pc,
`ifdef FETCH_TIMEOUT_EN
    output logic                    fetch_error,
`endif
    output logic                    busy,
    output logic                    fetch_done
);

    state_t state, state_nxt;
    logic   pc_ld, pc_inc, ack_take, start;
    logic   tmo_hit;

    assign busy     = (state == ST_READ);
    assign mem_read = busy;
    assign mem_addr = pc;
    assign opcode   = ir[DATA_WIDTH-1 -: OPCODE_WIDTH];
    assign ack_take = busy & mem_ack;
    assign start    = (state == ST_IDLE) & fetch;

`ifdef FETCH_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] rd_cnt;

    // Abort on the TIMEOUT_CYCLES-th READ edge without ack; ack on that edge still wins.
    assign tmo_hit = busy & ~mem_ack & (rd_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rd_cnt      <= '0;
            fetch_error <= 1'b0;
        end else begin
            if (start) begin
                rd_cnt      <= '0;
                fetch_error <= 1'b0;
            end else if (busy && !mem_ack) begin
                rd_cnt <= rd_cnt + 1'b1;
            end
            if (tmo_hit) begin
                fetch_error <= 1'b1;
            end
        end
    end
`else
    assign tmo_hit = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        pc_ld     = 1'b0;
        pc_inc    = 1'b0;
        case (state)
            ST_IDLE: begin
                pc_ld = pc_load;
                if (fetch) begin
                    state_nxt = ST_READ;
                end
            end
            ST_READ: begin
                if (mem_ack) begin
                    state_nxt = ST_IDLE;
                    pc_inc    = 1'b1;
                end else if (tmo_hit) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state      <= ST_IDLE;
            ir         <= '0;
            fetch_done <= 1'b0;
            carry      <= 1'b0;
            zero       <= 1'b0;
        end else begin
            state      <= state_nxt;
            fetch_done <= ack_take;
            if (ack_take) begin
                ir <= mem_data;
            end
            if (flags_load) begin
                carry <= alu_carry;
                zero  <= alu_zero;
            end
        end
    end

    pc_counter #(
        .WIDTH    (ADDR_WIDTH),
        .RESET_PC (RESET_PC)
    ) u_pc (
        .clock      (clock),
        .reset      (reset),
        .load       (pc_ld),
        .load_value (pc_load_value),
        .inc        (pc_inc),
        .pc         (pc)
    );

endmodule
